// File: rtl/fft_helpers_twiddle_pkg.sv
// Shared definitions for the FFT twiddle sequencer: FSM state encoding
// and constant functions that size the index and stage fields from N.
package fft_helpers_twiddle_pkg;

   // Sequencer states: waiting for a stage request, or streaming one.
   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_RUN  = 1'b1;

   // Ceiling log2 usable in constant expressions (n >= 1).
   function automatic int clog2_f(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Exact log2 of a power-of-two FFT size.
   function automatic int log2_f(input int n);
      return clog2_f(n);
   endfunction

   // Width of the stage request field: enough to name every stage, minimum 1.
   function automatic int stage_width_f(input int n);
      int w;
      w = clog2_f(log2_f(n));
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/fft_helpers_twiddle_lane.sv
// One twiddle lane: maps butterfly index k at stage s onto the sine table
// and returns (cos, -/+sin). Purely combinational; the caller registers it.
// The stage input must already be clamped to log2(N)-1.
module fft_helpers_twiddle_lane
   import fft_helpers_twiddle_pkg::*;
#(
   parameter  int BIT_WIDTH = 16,
   parameter  int SIZE_FFT  = 8,
   localparam int LOGN      = log2_f(SIZE_FFT),
   localparam int KW        = LOGN - 1,
   localparam int SW        = stage_width_f(SIZE_FFT)
) (
   input  logic [KW-1:0]                        k_i,
   input  logic [SW-1:0]                        stage_i,
   input  logic                                 inverse_i,
   input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]   table_i,
   output logic [BIT_WIDTH-1:0]                 real_o,
   output logic [BIT_WIDTH-1:0]                 imag_o
);

   // Two's complement negate that maps the most negative code to the
   // most positive one instead of wrapping back onto itself.
   function automatic logic [BIT_WIDTH-1:0] sat_neg(input logic [BIT_WIDTH-1:0] v);
      logic [BIT_WIDTH-1:0] min_v;
      min_v = {1'b1, {(BIT_WIDTH-1){1'b0}}};
      if (v == min_v) begin
         sat_neg = ~min_v;
      end else begin
         sat_neg = (~v) + {{(BIT_WIDTH-1){1'b0}}, 1'b1};
      end
   endfunction

   logic [LOGN-1:0]      mask_s;
   logic [LOGN-1:0]      m_s;
   logic [LOGN-1:0]      shamt_s;
   logic [LOGN-1:0]      idx_s;
   logic [LOGN-1:0]      ridx_s;
   logic [BIT_WIDTH-1:0] sine_s;

   // Table addressing: m = k mod 2^s, idx = m * N / 2^(s+1), cosine is the
   // sine a quarter period later; LOGN-bit arithmetic gives the mod N wrap.
   always_comb begin
      mask_s = '0;
      for (int b = 0; b < LOGN; b++) begin
         mask_s[b] = (32'(b) < 32'(stage_i));
      end
      m_s     = {1'b0, k_i} & mask_s;
      shamt_s = LOGN'(LOGN - 1) - LOGN'(stage_i);
      idx_s   = m_s << shamt_s;
      ridx_s  = idx_s + LOGN'(SIZE_FFT / 4);
      sine_s  = table_i[idx_s];
      real_o  = table_i[ridx_s];
      if (inverse_i) begin
         imag_o = sine_s;
      end else begin
         imag_o = sat_neg(sine_s);
      end
   end

endmodule

// File: rtl/fft_helpers_twiddle_sequencer.sv
// Twiddle-factor sequencer: on a stage request, streams the N/2 twiddles of
// that FFT stage, LANES per beat, over a valid/ready interface with
// registered outputs and no bubbles between beats.
module fft_helpers_twiddle_sequencer
   import fft_helpers_twiddle_pkg::*;
#(
   parameter  int BIT_WIDTH  = 16,
   parameter  int DECIMAL_PT = 8,
   parameter  int SIZE_FFT   = 8,
   parameter  int LANES      = 2,
   localparam int LOGN       = log2_f(SIZE_FFT),
   localparam int SW         = stage_width_f(SIZE_FFT),
   localparam int BW         = LOGN - 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]   sine_wave_in,
   input  logic                                 start_val,
   output logic                                 start_rdy,
   input  logic [SW-1:0]                        start_stage,
   input  logic                                 start_inverse,
   output logic                                 out_val,
   input  logic                                 out_rdy,
   output logic [LANES-1:0][BIT_WIDTH-1:0]      out_real,
   output logic [LANES-1:0][BIT_WIDTH-1:0]      out_imag,
   output logic [BW-1:0]                        out_base,
   output logic                                 out_last,
   output logic                                 busy
);

   // The fixed-point position only documents the table format; reject
   // a configuration where it cannot fit in the word.
   if (DECIMAL_PT >= BIT_WIDTH) begin : g_bad_decimal_pt
      $error("DECIMAL_PT must be smaller than BIT_WIDTH");
   end

   localparam logic [BW-1:0] BASE_STEP = BW'(LANES);
   localparam logic [BW-1:0] BASE_LAST = BW'(SIZE_FFT / 2 - LANES);
   localparam logic [SW-1:0] STAGE_MAX = SW'(LOGN - 1);

   state_t                          state_q, state_d;
   logic [SW-1:0]                   stage_q, stage_d;
   logic                            inv_q, inv_d;
   logic [BW-1:0]                   base_q, base_d;
   logic                            val_q, val_d;
   logic                            last_q, last_d;
   logic [LANES-1:0][BIT_WIDTH-1:0] real_q, real_d;
   logic [LANES-1:0][BIT_WIDTH-1:0] imag_q, imag_d;

   logic [SW-1:0]                   stage_clamped_s;
   logic [BW-1:0]                   lane_base_s;
   logic [SW-1:0]                   lane_stage_s;
   logic                            lane_inv_s;
   logic [LANES-1:0][BW-1:0]        lane_k_s;
   logic [LANES-1:0][BIT_WIDTH-1:0] lane_real_s;
   logic [LANES-1:0][BIT_WIDTH-1:0] lane_imag_s;
   logic                            start_fire_s;
   logic                            out_fire_s;

   assign start_fire_s = start_val && (state_q == ST_IDLE);
   assign out_fire_s   = val_q && out_rdy;

   // Requests beyond the last stage behave as the last stage.
   always_comb begin
      if (32'(start_stage) > 32'(LOGN - 1)) begin
         stage_clamped_s = STAGE_MAX;
      end else begin
         stage_clamped_s = start_stage;
      end
   end

   // Lanes always compute the beat that would be loaded on the next edge:
   // beat 0 of the requested stage when idle, the following beat when running.
   always_comb begin
      if (state_q == ST_IDLE) begin
         lane_base_s  = '0;
         lane_stage_s = stage_clamped_s;
         lane_inv_s   = start_inverse;
      end else begin
         lane_base_s  = base_q + BASE_STEP;
         lane_stage_s = stage_q;
         lane_inv_s   = inv_q;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lane_k_s[g] = lane_base_s + BW'(g);

      fft_helpers_twiddle_lane #(
         .BIT_WIDTH (BIT_WIDTH),
         .SIZE_FFT  (SIZE_FFT)
      ) u_lane (
         .k_i       (lane_k_s[g]),
         .stage_i   (lane_stage_s),
         .inverse_i (lane_inv_s),
         .table_i   (sine_wave_in),
         .real_o    (lane_real_s[g]),
         .imag_o    (lane_imag_s[g])
      );
   end

   // Stream control: accept a request in IDLE, advance one beat per
   // handshake in RUN, and drop back to IDLE after the final beat.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      inv_d   = inv_q;
      base_d  = base_q;
      val_d   = val_q;
      last_d  = last_q;
      real_d  = real_q;
      imag_d  = imag_q;
      case (state_q)
         ST_IDLE: begin
            if (start_fire_s) begin
               state_d = ST_RUN;
               stage_d = stage_clamped_s;
               inv_d   = start_inverse;
               base_d  = lane_base_s;
               val_d   = 1'b1;
               last_d  = (lane_base_s == BASE_LAST);
               real_d  = lane_real_s;
               imag_d  = lane_imag_s;
            end else begin
               val_d   = 1'b0;
            end
         end
         ST_RUN: begin
            if (out_fire_s) begin
               if (last_q) begin
                  state_d = ST_IDLE;
                  base_d  = '0;
                  val_d   = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  base_d  = lane_base_s;
                  last_d  = (lane_base_s == BASE_LAST);
                  real_d  = lane_real_s;
                  imag_d  = lane_imag_s;
               end
            end else begin
               val_d   = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            base_d  = '0;
            val_d   = 1'b0;
            last_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any stream in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         stage_q <= '0;
         inv_q   <= 1'b0;
         base_q  <= '0;
         val_q   <= 1'b0;
         last_q  <= 1'b0;
         real_q  <= '0;
         imag_q  <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         inv_q   <= inv_d;
         base_q  <= base_d;
         val_q   <= val_d;
         last_q  <= last_d;
         real_q  <= real_d;
         imag_q  <= imag_d;
      end
   end

   assign start_rdy = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_RUN);
   assign out_val   = val_q;
   assign out_last  = last_q;
   assign out_base  = base_q;
   assign out_real  = real_q;
   assign out_imag  = imag_q;

endmodule

// File: tb/tb_fft_helpers_twiddle_sequencer.sv
// Scoreboard bench for the twiddle sequencer: each stage request pushes its
// expected beats (from a formula-level reference model) into a queue, and a
// monitor pops and compares on every output handshake.
module tb_fft_helpers_twiddle_sequencer;

   localparam int N     = 8;
   localparam int L     = 2;
   localparam int W     = 16;
   localparam int SW    = 2;
   localparam int KW    = 2;
   localparam int BEATS = N / (2 * L);

   typedef struct packed {
      logic [KW-1:0]       base;
      logic                last;
      logic [L-1:0][W-1:0] re;
      logic [L-1:0][W-1:0] im;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset;
   logic [N-1:0][W-1:0] sine_in;
   logic                start_val;
   logic                start_rdy;
   logic [SW-1:0]       start_stage;
   logic                start_inverse;
   logic                out_val;
   logic                out_rdy;
   logic [L-1:0][W-1:0] out_real;
   logic [L-1:0][W-1:0] out_imag;
   logic [KW-1:0]       out_base;
   logic                out_last;
   logic                busy;

   fft_helpers_twiddle_sequencer #(
      .BIT_WIDTH (W), .DECIMAL_PT (8), .SIZE_FFT (N), .LANES (L)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .sine_wave_in  (sine_in),
      .start_val     (start_val),
      .start_rdy     (start_rdy),
      .start_stage   (start_stage),
      .start_inverse (start_inverse),
      .out_val       (out_val),
      .out_rdy       (out_rdy),
      .out_real      (out_real),
      .out_imag      (out_imag),
      .out_base      (out_base),
      .out_last      (out_last),
      .busy          (busy)
   );

   int    errors = 0;
   int    checks = 0;
   int    sine_m [N];
   beat_t exp_q [$];
   bit    rand_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: twiddle k at stage s straight from the definition.
   function automatic void model(input int k, input int s, input bit inv,
                                 output logic [W-1:0] re, output logic [W-1:0] im);
      int ss, m, idx, v;
      ss  = (s >= 3) ? 2 : s;
      m   = k % (1 << ss);
      idx = m * N / (1 << (ss + 1));
      re  = W'(sine_m[(idx + N / 4) % N]);
      v   = sine_m[idx];
      if (inv) im = W'(v);
      else if (v == -32768) im = 16'h7FFF;
      else im = W'(-v);
   endfunction

   function automatic beat_t make_beat(input int j, input int s, input bit inv);
      beat_t b;
      logic [W-1:0] r, i;
      b.base = KW'(j * L);
      b.last = (j == BEATS - 1);
      for (int l = 0; l < L; l++) begin
         model(j * L + l, s, inv, r, i);
         b.re[l] = r;
         b.im[l] = i;
      end
      return b;
   endfunction

   task automatic set_table(input int t [N]);
      for (int i = 0; i < N; i++) begin
         sine_m[i]  = t[i];
         sine_in[i] = W'(t[i]);
      end
   endtask

   task automatic set_default_table();
      int t [N];
      t = '{0, 181, 256, 181, 0, -181, -256, -181};
      set_table(t);
   endtask

   // Issue one stage request (called at posedge+1), queue its expected beats.
   task automatic run_stage(input int s, input bit inv);
      int n;
      n = 0;
      while (!start_rdy && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (!start_rdy) chk("start_rdy_timeout", 64'(start_rdy), 64'd1);
      for (int j = 0; j < BEATS; j++) exp_q.push_back(make_beat(j, s, inv));
      start_stage   = SW'(s);
      start_inverse = inv;
      start_val     = 1'b1;
      @(posedge clk); #1;
      start_val     = 1'b0;
      chk("latency_out_val", 64'(out_val), 64'd1);
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_start_rdy", 64'(start_rdy), 64'd0);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 200) chk("drain_timeout", 64'd1, 64'd0);
   endtask

   // Monitor: every handshake consumes exactly one expected beat.
   always @(negedge clk) begin
      beat_t b;
      if (reset && out_val && out_rdy) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(out_base), 64'hFFFF);
         end else begin
            b = exp_q.pop_front();
            chk("beat_base", 64'(out_base), 64'(b.base));
            chk("beat_last", 64'(out_last), 64'(b.last));
            chk("beat_real", 64'(out_real), 64'(b.re));
            chk("beat_imag", 64'(out_imag), 64'(b.im));
         end
      end
   end

   // Random backpressure driver.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_en) out_rdy = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      beat_t h;
      int    t [N];
      logic signed [W-1:0] rv;

      reset = 1'b0; start_val = 1'b0; start_stage = '0; start_inverse = 1'b0;
      out_rdy = 1'b1;
      set_default_table();
      #3;
      chk("reset_out_val", 64'(out_val), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_start_rdy", 64'(start_rdy), 64'd1);
      chk("reset_out_base", 64'(out_base), 64'd0);
      chk("reset_out_last", 64'(out_last), 64'd0);
      chk("reset_out_data", 64'({out_real, out_imag}), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // Stage 0 forward, full-rate, with explicit end-of-stream timing.
      run_stage(0, 1'b0);
      @(posedge clk); #1;
      chk("s0_beat1_base", 64'(out_base), 64'd2);
      chk("s0_beat1_last", 64'(out_last), 64'd1);
      @(posedge clk); #1;
      chk("end_out_val", 64'(out_val), 64'd0);
      chk("end_start_rdy", 64'(start_rdy), 64'd1);
      chk("end_out_base", 64'(out_base), 64'd0);
      wait_done();

      // Stage 2 forward and inverse, then an out-of-range stage.
      run_stage(2, 1'b0); wait_done();
      run_stage(2, 1'b1); wait_done();
      run_stage(3, 1'b0); wait_done();

      // Backpressure: beat 0 held for 3 cycles, start_val during RUN ignored.
      out_rdy = 1'b0;
      run_stage(2, 1'b0);
      h = make_beat(0, 2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         start_val = (i == 0);
         @(posedge clk); #1;
         chk("stall_val", 64'(out_val), 64'd1);
         chk("stall_base", 64'(out_base), 64'd0);
         chk("stall_real", 64'(out_real), 64'(h.re));
         chk("stall_imag", 64'(out_imag), 64'(h.im));
      end
      start_val = 1'b0;
      out_rdy = 1'b1;
      @(posedge clk); #1;
      chk("after_stall_base", 64'(out_base), 64'd2);
      @(posedge clk); #1;
      repeat (4) begin
         @(posedge clk); #1;
         chk("ignored_start_val", 64'(out_val), 64'd0);
      end
      wait_done();

      // Saturating negation of the most negative table entry.
      t = '{0, -32768, 256, 181, 0, -181, -256, -181};
      set_table(t);
      run_stage(2, 1'b0);
      chk("sat_imag_k1", 64'(out_imag[1]), 64'h7FFF);
      wait_done();
      set_default_table();

      // Reset during beat 1 aborts the stream; a fresh start works after.
      run_stage(2, 1'b0);
      @(posedge clk); #1;
      chk("pre_abort_base", 64'(out_base), 64'd2);
      #1;
      reset = 1'b0;
      exp_q.delete();
      #1;
      chk("abort_out_val", 64'(out_val), 64'd0);
      chk("abort_out_base", 64'(out_base), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      run_stage(1, 1'b0);
      chk("s1_beat0_real", 64'(out_real), 64'({16'd0, 16'd256}));
      chk("s1_beat0_imag", 64'(out_imag), 64'({16'hFF00, 16'd0}));
      wait_done();

      // Randomized tables, stages, direction and backpressure.
      rand_en = 1'b1;
      for (int it = 0; it < 30; it++) begin
         for (int i = 0; i < N; i++) begin
            rv = W'($urandom);
            if ($urandom_range(0, 7) == 0) rv = 16'sh8000;
            t[i] = int'(rv);
         end
         set_table(t);
         run_stage(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         wait_done();
      end
      rand_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fft_helpers_twiddle_sequencer.md
FFT_HELPERS_TWIDDLE_SEQUENCER -- requirements
Module: fft_helpers_twiddle_sequencer

Interface
REQ-001 Parameter BIT_WIDTH, default 16: width of each twiddle component, two's complement.
REQ-002 Parameter DECIMAL_PT, default 8: fractional bits. Carried for documentation; no arithmetic uses it.
REQ-003 Parameter SIZE_FFT, default 8: FFT points N. Power of two, N >= 4.
REQ-004 Parameter LANES, default 2: twiddles per output beat. Power of two; divides N/2.
REQ-005 clk  in  1: single clock; all state changes on its rising edge.
REQ-006 reset  in  1: asynchronous, active-low reset.
REQ-007 sine_wave_in  in  BIT_WIDTH x N: sin(2*pi*m/N) table. Treated as static while busy.
REQ-008 start_val  in  1; start_rdy  out  1: stage-request handshake.
REQ-009 start_stage  in  $clog2(log2 N) (min 1): requested stage s.
REQ-010 start_inverse  in  1: 1 = conjugate twiddles (IFFT).
REQ-011 out_val  out  1; out_rdy  in  1: twiddle-stream handshake.
REQ-012 out_real, out_imag  out  BIT_WIDTH x LANES: twiddles k = out_base .. out_base+LANES-1.
REQ-013 out_base  out  $clog2(N/2): butterfly index of lane 0.
REQ-014 out_last  out  1: the current beat is the final beat of the stage.
REQ-015 busy  out  1: a stage stream is in progress.

Function
REQ-016 FSM states: IDLE, RUN. start_rdy = (state == IDLE). busy = (state == RUN).
REQ-017 IDLE -> RUN when start_val && start_rdy. On that edge: latch stage and inverse, set out_base = 0, assert out_val.
REQ-018 Stages s >= log2 N are clamped to log2 N - 1.
REQ-019 Twiddle for index k at stage s:
  - m = k mod 2^s
  - idx = m * N / 2^(s+1)
  - real = sine[(idx + N/4) mod N]
  - imag = -sine[idx] when forward; +sine[idx] when inverse.
REQ-020 Negation saturates: -(-2^(BIT_WIDTH-1)) yields 2^(BIT_WIDTH-1)-1. All other values are exact.
REQ-021 Outputs are registered. Beat 0 is valid in the first cycle after the start handshake (latency 1).
REQ-022 Each handshake (out_val && out_rdy) advances out_base by LANES and loads the next beat on the same edge. There are no bubbles.
REQ-023 With out_val high and out_rdy low, all outputs hold stable.
REQ-024 The stream has N/(2*LANES) beats. out_last is asserted only on the final beat.
REQ-025 A handshake on the final beat returns the FSM to IDLE and deasserts out_val. start_rdy rises the following cycle.
REQ-026 start_val while in RUN is ignored and not queued.
REQ-027 out_base wraps only at stage end. No partial final beat exists.

Reset
REQ-028 While reset = 0:
  - state = IDLE
  - out_val, out_last, busy = 0
  - out_base = 0
  - out_real, out_imag = 0
  - latched stage and inverse = 0
REQ-029 Assertion mid-stream aborts the stream immediately. After release, the block accepts a new start.

Structure
REQ-030 Shared package fft_helpers_twiddle_pkg holds the state enum and the constant function clog2/log2 for N.
REQ-031 Sub-module fft_helpers_twiddle_lane: combinational (k, s, inverse, table) -> (real, imag), including saturation. Instantiated LANES times.
REQ-032 Lint-clean for the parameter sets N ∈ {4, 8, 32}, LANES ∈ {1, 2, N/2}.

Verification
Common setup: BIT_WIDTH = 16, DECIMAL_PT = 8, N = 8, LANES = 2. Table = {0, 181, 256, 181, 0, -181, -256, -181}.
REQ-033 Forward, stage 0, out_rdy = 1:
  - beat 0 = {(256,0), (256,0)}, out_base 0
  - beat 1 = {(256,0), (256,0)}, out_base 2, out_last = 1
REQ-034 Forward, stage 2:
  - beat 0 = {(256,0), (181,-181)}
  - beat 1 = {(0,-256), (-181,-181)}
  - Inverse, stage 2: imag becomes {0, 181, 256, 181}.
REQ-035 Stage 2 with out_rdy low for 3 cycles on beat 0: outputs hold 3 cycles; beat 1 follows the cycle after rdy rises. start_val pulsed during RUN is ignored.
REQ-036 Table entry sine[1] = 0x8000, forward stage 2: k = 1 imag = 0x7FFF (saturated).
REQ-037 Reset asserted during beat 1 of stage 2:
  - out_val = 0 and out_base = 0 immediately
  - after release, a stage-1 start streams {(256,0), (0,-256)} twice.
